// File: rtl/coin_acceptor_pkg.sv
// Shared definitions for the coin acceptor: FSM state encoding, coin-value
// width, default coin values and the type-code to value mapping.
package coin_acceptor_pkg;

    localparam int unsigned COIN_W = 8;

    localparam logic [COIN_W-1:0] VAL0_DEF = 8'd5;
    localparam logic [COIN_W-1:0] VAL1_DEF = 8'd10;
    localparam logic [COIN_W-1:0] VAL2_DEF = 8'd25;
    localparam logic [COIN_W-1:0] VAL3_DEF = 8'd0;

    typedef enum logic [2:0] {
        WAIT_LOW = 3'd0,
        IDLE     = 3'd1,
        QUAL_IN  = 3'd2,
        HELD     = 3'd3,
        QUAL_OUT = 3'd4,
        EMIT     = 3'd5
    } state_e;

    // A zero result marks the type code as invalid (coin is rejected).
    function automatic logic [COIN_W-1:0] coin_value(
        input logic [1:0]        code,
        input logic [COIN_W-1:0] v0,
        input logic [COIN_W-1:0] v1,
        input logic [COIN_W-1:0] v2,
        input logic [COIN_W-1:0] v3
    );
        logic [COIN_W-1:0] val;
        case (code)
            2'd0:    val = v0;
            2'd1:    val = v1;
            2'd2:    val = v2;
            2'd3:    val = v3;
            default: val = {COIN_W{1'b0}};
        endcase
        return val;
    endfunction

endpackage

// File: rtl/coin_acceptor_sync2.sv
// Two-flop synchronizer for asynchronous inputs, cleared by the
// asynchronous active-high reset.
module coin_acceptor_sync2
    import coin_acceptor_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability filter: two back-to-back capture stages.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= {WIDTH{1'b0}};
            sync_q <= {WIDTH{1'b0}};
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin-in front end: synchronises and debounces the coin sensor and emits a
// one-cycle deposit strobe with the coin value, or a one-cycle reject strobe.
module coin_acceptor
    import coin_acceptor_pkg::*;
#(
    parameter int unsigned       DEBOUNCE = 4,
    parameter logic [COIN_W-1:0] VAL0     = VAL0_DEF,
    parameter logic [COIN_W-1:0] VAL1     = VAL1_DEF,
    parameter logic [COIN_W-1:0] VAL2     = VAL2_DEF,
    parameter logic [COIN_W-1:0] VAL3     = VAL3_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sense,
    input  logic [1:0]        type_code,
    input  logic              enable,
    output logic              c,
    output logic [COIN_W-1:0] a,
    output logic              reject,
    output logic              busy
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic              sense_s;
    logic [1:0]        type_s;
    logic [COIN_W-1:0] coin_val_s;

    state_e            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [1:0]        type_q,   type_d;
    logic              c_q,      c_d;
    logic [COIN_W-1:0] a_q,      a_d;
    logic              reject_q, reject_d;
    logic              busy_q,   busy_d;
    logic [1:0]        fill_q;

    coin_acceptor_sync2 #(.WIDTH(1)) u_sync_sense (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (sense),
        .q_o   (sense_s)
    );

    coin_acceptor_sync2 #(.WIDTH(2)) u_sync_type (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (type_code),
        .q_o   (type_s)
    );

    assign coin_val_s = coin_value(type_q, VAL0, VAL1, VAL2, VAL3);

    // Marks when the synchronizer holds real pin data again after reset, so a
    // coin lodged across reset is not mistaken for an empty slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= 2'b00;
        end else begin
            fill_q <= {fill_q[0], 1'b1};
        end
    end

    // Next-state, debounce counter, type capture and strobe decision.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        type_d   = type_q;
        c_d      = 1'b0;
        a_d      = {COIN_W{1'b0}};
        reject_d = 1'b0;
        case (state_q)
            WAIT_LOW: begin
                if (fill_q[1] && !sense_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_LOW;
                end
            end
            IDLE: begin
                if (sense_s) begin
                    state_d = QUAL_IN;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            QUAL_IN: begin
                if (!sense_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    type_d  = type_s;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!sense_s) begin
                    state_d = QUAL_OUT;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = HELD;
                end
            end
            QUAL_OUT: begin
                if (sense_s) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = EMIT;
                    if ((coin_val_s != {COIN_W{1'b0}}) && enable) begin
                        c_d = 1'b1;
                        a_d = coin_val_s;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            EMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = WAIT_LOW;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_LOW;
            cnt_q    <= {CNT_W{1'b0}};
            type_q   <= 2'b00;
            c_q      <= 1'b0;
            a_q      <= {COIN_W{1'b0}};
            reject_q <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            type_q   <= type_d;
            c_q      <= c_d;
            a_q      <= a_d;
            reject_q <= reject_d;
            busy_q   <= busy_d;
        end
    end

    assign c      = c_q;
    assign a      = a_q;
    assign reject = reject_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus randomized
// coins, with strobe edges predicted from the debounce timing rules.
module tb_coin_acceptor;

    localparam int D    = 4;
    localparam int NEXP = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic       sense;
    logic [1:0] type_code;
    logic       enable;
    logic       c;
    logic [7:0] a;
    logic       reject;
    logic       busy;

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;

    // Expected outputs after each clock edge, indexed by edge number.
    bit       exp_c [NEXP];
    bit       exp_r [NEXP];
    bit [7:0] exp_a [NEXP];
    int       vals  [4] = '{5, 10, 25, 0};

    coin_acceptor dut (
        .clk       (clk),
        .rst       (rst),
        .sense     (sense),
        .type_code (type_code),
        .enable    (enable),
        .c         (c),
        .a         (a),
        .reject    (reject),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, cyc, obs, expv);
        end
    endtask

    // One clock: advance past the edge and compare all strobe outputs.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cyc >= NEXP) begin
            $display("FAIL edge_budget: edge %0d exceeds %0d", cyc, NEXP);
            $fatal(1);
        end
        check("c",      {7'd0, c},      {7'd0, exp_c[cyc]});
        check("a",      a,              exp_a[cyc]);
        check("reject", {7'd0, reject}, {7'd0, exp_r[cyc]});
        check("c_rej_exclusive", {7'd0, c & reject}, 8'd0);
    endtask

    // A falling edge driven now is captured at the next edge (k); the strobe
    // appears D+2 edges after k.
    task automatic predict(input int code, input bit en, output int e);
        e = cyc + 1 + D + 2;
        if (vals[code] != 0 && en) begin
            exp_c[e] = 1'b1;
            exp_a[e] = vals[code][7:0];
        end else begin
            exp_r[e] = 1'b1;
        end
    endtask

    // Coin: high for hi cycles, optional trailing bounce (bl low, bh high),
    // then low for gap cycles. Enable wanders while the coin is in the slot.
    task automatic coin(input int code, input bit en, input int hi, input int bl,
                        input int bh, input int gap, output int e);
        sense     = 1'b1;
        type_code = code[1:0];
        for (int i = 0; i < hi; i++) begin
            tick();
            enable = 1'($urandom_range(0, 1));
        end
        if (hi >= 3) check("busy_in_coin", {7'd0, busy}, 8'd1);
        if (bl > 0) begin
            sense = 1'b0;
            repeat (bl) tick();
            sense = 1'b1;
            repeat (bh) tick();
        end
        sense  = 1'b0;
        enable = en;
        e      = -1;
        if (hi >= D + 1) predict(code, en, e);
        repeat (gap) tick();
        if (gap >= D + 4) check("busy_idle", {7'd0, busy}, 8'd0);
    endtask

    initial begin
        int e;
        rst       = 1'b1;
        sense     = 1'b0;
        type_code = 2'd0;
        enable    = 1'b0;
        #12;
        check("rst_c",      {7'd0, c},      8'd0);
        check("rst_a",      a,              8'd0);
        check("rst_reject", {7'd0, reject}, 8'd0);
        check("rst_busy",   {7'd0, busy},   8'd1);
        @(negedge clk) rst = 1'b0;
        repeat (4) tick();
        check("idle_after_rst", {7'd0, busy}, 8'd0);

        // Type 1 coin, then an asynchronous reset during the EMIT cycle.
        coin(1, 1'b1, 10, 0, 0, 0, e);
        while (cyc < e) tick();
        #2 rst = 1'b1;
        #1;
        check("async_rst_c",      {7'd0, c},      8'd0);
        check("async_rst_a",      a,              8'd0);
        check("async_rst_reject", {7'd0, reject}, 8'd0);
        check("async_rst_busy",   {7'd0, busy},   8'd1);
        @(negedge clk) rst = 1'b0;
        repeat (4) tick();
        coin(1, 1'b1, 10, 0, 0, 12, e);

        // Short pulse discarded; bounced trailing edge; invalid and disabled.
        coin(2, 1'b1, 3, 0, 0, 10, e);
        coin(2, 1'b1, 10, 2, 3, 12, e);
        coin(3, 1'b1, 8, 0, 0, 12, e);
        coin(0, 1'b0, 8, 0, 0, 12, e);
        coin(1, 1'b1, D, 0, 0, 10, e);
        coin(1, 1'b1, D + 1, D, 1, 12, e);

        // Coin lodged in the slot across reset is neither credited nor rejected.
        sense     = 1'b1;
        type_code = 2'd0;
        enable    = 1'b1;
        repeat (10) tick();
        #2 rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        repeat (20) tick();
        check("lodged_busy", {7'd0, busy}, 8'd1);
        sense = 1'b0;
        repeat (D + 4) tick();
        check("lodged_clear", {7'd0, busy}, 8'd0);
        coin(0, 1'b1, 8, 0, 0, 12, e);

        // Back-to-back minimal coins: strobes 2*D+3 edges apart.
        coin(1, 1'b1, D + 1, 0, 0, D + 2, e);
        coin(1, 1'b1, D + 1, 0, 0, D + 2, e);
        coin(2, 1'b1, D + 1, 0, 0, 12, e);

        // Randomized coins.
        for (int n = 0; n < 30; n++) begin
            int code, hi, bl, bh, gap;
            bit en;
            code = int'($urandom_range(0, 3));
            en   = ($urandom_range(0, 3) != 0);
            hi   = int'($urandom_range(1, D + 6));
            bl   = 0;
            bh   = 0;
            if (hi >= D + 1 && $urandom_range(0, 1) == 1) begin
                bl = int'($urandom_range(1, D));
                bh = int'($urandom_range(1, 3));
            end
            gap = int'($urandom_range(D + 2, D + 8));
            coin(code, en, hi, bl, bh, gap, e);
        end
        repeat (D + 6) tick();
        check("final_idle", {7'd0, busy}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
